free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list.sv | 113 +++++++++++
 tb/tb_free_list.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list -- physical register free list for a two-wide rename stage.
//
// A circular FIFO of physical register IDs. Rename pops up to two IDs per
// cycle (all-or-nothing); commit pushes back up to two released IDs per cycle.
// After reset the list holds XLEN..NB_PHYS_REGS-1; registers 0..XLEN-1 start
// out mapped to the architectural registers and are never in the list.
//
// Ports:
//   clk, reset                     single clock, synchronous active-high reset
//   instr0_alloc_req/instr1_...    rename requests a destination register
//   alloc_ok                       every asserted request can be granted now
//   instr0_phys_rd/instr1_phys_rd  granted IDs (combinational reads)
//   free0_v/free0_phys             release port 0 (written first)
//   free1_v/free1_phys             release port 1
//   free_cnt                       registered number of free entries
//   overflow_err                   sticky: a release arrived with no room
// -----------------------------------------------------------------------------
module free_list #(
  parameter int NB_PHYS_REGS        = 64,
  parameter int PHYS_REGS_ADDR_SIZE = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           instr0_alloc_req,
  input  logic                           instr1_alloc_req,
  output logic                           alloc_ok,
  output logic [PHYS_REGS_ADDR_SIZE-1:0] instr0_phys_rd,
  output logic [PHYS_REGS_ADDR_SIZE-1:0] instr1_phys_rd,
  input  logic                           free0_v,
  input  logic [PHYS_REGS_ADDR_SIZE-1:0] free0_phys,
  input  logic                           free1_v,
  input  logic [PHYS_REGS_ADDR_SIZE-1:0] free1_phys,
  output logic [PHYS_REGS_ADDR_SIZE:0]   free_cnt,
  output logic                           overflow_err
);

  localparam int XLEN = 32;
  localparam int AW   = PHYS_REGS_ADDR_SIZE;
  localparam int CW   = PHYS_REGS_ADDR_SIZE + 1;

  typedef logic [AW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t FULL_CNT  = cnt_t'(NB_PHYS_REGS);
  localparam cnt_t RESET_CNT = cnt_t'(NB_PHYS_REGS - XLEN);

  idx_t entry [NB_PHYS_REGS];
  idx_t head;
  idx_t tail;
  cnt_t cnt;
  logic ovf;

  logic [1:0] nreq;
  logic [1:0] npop;
  logic [1:0] nacc;
  logic       acc0;
  logic       acc1;
  logic       drop;
  cnt_t       cnt_next;

  // Requests/grants --------------------------------------------------------
  assign nreq     = {1'b0, instr0_alloc_req} + {1'b0, instr1_alloc_req};
  assign alloc_ok = (cnt >= cnt_t'(nreq));
  assign npop     = alloc_ok ? nreq : 2'd0;

  // instr1 takes the entry after instr0's only when instr0 is also allocating.
  assign instr0_phys_rd = entry[head];
  assign instr1_phys_rd = entry[head + idx_t'(instr0_alloc_req)];

  // Releases ---------------------------------------------------------------
  // Room is judged against the registered count, before this cycle's pops,
  // so a release never relies on a same-cycle allocation to make space.
  // When only one slot is left, port 0 wins and port 1 is dropped.
  always_comb begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    acc0 = free0_v && (cnt < FULL_CNT);
    acc1 = free1_v && ((cnt + cnt_t'(acc0)) < FULL_CNT);
  end

  assign nacc     = {1'b0, acc0} + {1'b0, acc1};
  assign drop     = (free0_v && !acc0) || (free1_v && !acc1);
  assign cnt_next = cnt + cnt_t'(nacc) - cnt_t'(npop);

  // State ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only the first NB_PHYS_REGS-XLEN slots need a reset value; the
      // rest are unreachable until written by a release, so they are left as
      // plain storage rather than given a reset they do not need.
      for (int i = 0; i < NB_PHYS_REGS - XLEN; i++) begin
        entry[i] <= idx_t'(XLEN + i);
      end
      head <= '0;
      tail <= idx_t'(NB_PHYS_REGS - XLEN);
      cnt  <= RESET_CNT;
      ovf  <= 1'b0;
    end else begin
      if (acc0) entry[tail] <= free0_phys;
      if (acc1) entry[tail + idx_t'(free0_v)] <= free1_phys;
      // Pointers wrap naturally: NB_PHYS_REGS is a power of two.
      head <= head + idx_t'(npop);
      tail <= tail + idx_t'(nacc);
      cnt  <= cnt_next;
      ovf  <= ovf | drop;
    end
  end

  assign free_cnt     = cnt;
  assign overflow_err = ovf;

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list -- directed self-checking bench for free_list.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr0_alloc_req;
  logic       instr1_alloc_req;
  logic       alloc_ok;
  logic [5:0] instr0_phys_rd;
  logic [5:0] instr1_phys_rd;
  logic       free0_v;
  logic [5:0] free0_phys;
  logic       free1_v;
  logic [5:0] free1_phys;
  logic [6:0] free_cnt;
  logic       overflow_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  free_list #(.NB_PHYS_REGS(64), .PHYS_REGS_ADDR_SIZE(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .instr0_alloc_req (instr0_alloc_req),
    .instr1_alloc_req (instr1_alloc_req),
    .alloc_ok         (alloc_ok),
    .instr0_phys_rd   (instr0_phys_rd),
    .instr1_phys_rd   (instr1_phys_rd),
    .free0_v          (free0_v),
    .free0_phys       (free0_phys),
    .free1_v          (free1_v),
    .free1_phys       (free1_phys),
    .free_cnt         (free_cnt),
    .overflow_err     (overflow_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic r0, input logic r1,
                       input logic f0v, input logic [5:0] f0,
                       input logic f1v, input logic [5:0] f1);
    instr0_alloc_req = r0;
    instr1_alloc_req = r1;
    free0_v          = f0v;
    free0_phys       = f0;
    free1_v          = f1v;
    free1_phys       = f1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
  endtask

  initial begin
    int q[$];
    int exp_id;
    int r;

    // Reset wins over requests presented alongside it.
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 6'd3, 1'b1, 6'd4);
    tick();
    tick();
    reset = 1'b0;
    idle();
    check("rst_cnt", free_cnt, 32);
    check("rst_ovf", overflow_err, 0);
    check("rst_rd0", instr0_phys_rd, 32);
    check("rst_ok_noreq", alloc_ok, 1);

    // Dual allocation after reset.
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    check("dual_ok", alloc_ok, 1);
    check("dual_rd0", instr0_phys_rd, 32);
    check("dual_rd1", instr1_phys_rd, 33);
    tick();
    idle();
    check("dual_cnt", free_cnt, 30);
    check("dual_next_rd0", instr0_phys_rd, 34);

    // instr1 alone takes the head entry.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    check("i1_only_rd1", instr1_phys_rd, 32);
    tick();
    idle();
    check("i1_only_cnt", free_cnt, 31);

    // Drain 31 -> 1 two at a time.
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      check("drain_rd0", instr0_phys_rd, 33 + 2 * k);
      check("drain_rd1", instr1_phys_rd, 34 + 2 * k);
      tick();
    end
    idle();
    check("drain_cnt1", free_cnt, 1);

    // Two requests with one free entry: refused, nothing moves.
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    check("short_ok", alloc_ok, 0);
    tick();
    idle();
    check("short_cnt", free_cnt, 1);
    check("short_head", instr0_phys_rd, 63);

    // One request with one free entry: granted.
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    check("last_ok", alloc_ok, 1);
    check("last_rd0", instr0_phys_rd, 63);
    tick();
    idle();
    check("empty_cnt", free_cnt, 0);
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    check("empty_one_ok", alloc_ok, 0);

    // Empty list, allocate and release together: refused, releases kept.
    drive(1'b1, 1'b1, 1'b1, 6'd5, 1'b1, 6'd7);
    check("empty_rel_ok", alloc_ok, 0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    check("rel_cnt", free_cnt, 2);
    check("rel_ok", alloc_ok, 1);
    check("rel_rd0", instr0_phys_rd, 5);
    check("rel_rd1", instr1_phys_rd, 7);
    tick();
    idle();
    check("rel_cnt_after", free_cnt, 0);
    check("rel_ovf", overflow_err, 0);

    // Fill to 64 with IDs 0..63 in order.
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 1'b0, 1'b1, 6'(2 * k), 1'b1, 6'(2 * k + 1));
      tick();
    end
    idle();
    check("full_cnt", free_cnt, 64);
    check("full_ovf0", overflow_err, 0);

    // Release into a full list: dropped, error sticks.
    drive(1'b0, 1'b0, 1'b1, 6'd9, 1'b0, 6'd0);
    tick();
    idle();
    check("ovf_cnt", free_cnt, 64);
    check("ovf_flag", overflow_err, 1);

    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    check("full_rd0", instr0_phys_rd, 0);
    tick();
    idle();
    check("full_m1_cnt", free_cnt, 63);

    // One slot, two releases: port 0 kept, port 1 dropped.
    drive(1'b0, 1'b0, 1'b1, 6'd11, 1'b1, 6'd12);
    tick();
    idle();
    check("ovf2_cnt", free_cnt, 64);
    check("ovf2_flag", overflow_err, 1);

    // Drain everything: 1..63 then 11.
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      check("fdrain_rd0", instr0_phys_rd, 2 * k + 1);
      check("fdrain_rd1", instr1_phys_rd, (k == 31) ? 11 : 2 * k + 2);
      tick();
    end
    idle();
    check("fdrain_cnt", free_cnt, 0);
    check("ovf_sticky", overflow_err, 1);

    do_reset();
    check("rst2_ovf", overflow_err, 0);
    check("rst2_cnt", free_cnt, 32);

    // Wrap: 200 single alloc + single release pairs, alternating ports.
    for (int i = 32; i < 64; i++) q.push_back(i);
    for (int i = 0; i < 200; i++) begin
      r = (i * 7 + 3) % 64;
      if (i % 3 == 0) begin
        drive(1'b0, 1'b1, (i % 2 == 0), 6'(r), (i % 2 == 1), 6'(r));
      end else begin
        drive(1'b1, 1'b0, (i % 2 == 0), 6'(r), (i % 2 == 1), 6'(r));
      end
      exp_id = q.pop_front();
      q.push_back(r);
      if (i % 3 == 0) check("wrap_rd1", instr1_phys_rd, exp_id);
      else            check("wrap_rd0", instr0_phys_rd, exp_id);
      check("wrap_ok", alloc_ok, 1);
      tick();
      check("wrap_cnt", free_cnt, 32);
    end
    idle();
    check("wrap_ovf", overflow_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
